// File: rtl/rx_word_aligner.sv
// Bit-level word aligner for a rotated 32-bit receive stream: hunts all 32 offsets
// for the sync word, verifies frame spacing, then emits aligned words with SOF.
module rx_word_aligner #(
    parameter logic [31:0] SYNC_WORD  = 32'h1ACFFC1D,
    parameter int unsigned FRAME_LEN  = 16,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned MISS_LIMIT = 4
) (
    input  logic        RX_WORDCLK_i,
    input  logic        RX_RESET_i,
    input  logic [31:0] IN_DATA_i,
    input  logic        IN_VALID_i,
    input  logic        ERR_CLR_i,
    output logic [31:0] OUT_DATA_o,
    output logic        OUT_VALID_o,
    output logic        OUT_SOF_o,
    output logic        LOCKED_o,
    output logic [4:0]  OFFSET_o,
    output logic [15:0] SYNC_ERR_CNT_o
);
    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [15:0] WC_LAST = 16'(FRAME_LEN - 1);
    localparam logic [3:0]  LOCK_N  = 4'(LOCK_COUNT);
    localparam logic [3:0]  MISS_N  = 4'(MISS_LIMIT);

    state_t      state_q, state_d;
    logic [31:0] prev_q, prev_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic [3:0]  miss_cnt_q, miss_cnt_d;
    logic [4:0]  offset_q, offset_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_sof_q, out_sof_d;
    logic        locked_q, locked_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic [63:0] window;
    logic [31:0] hit_vec;
    logic        hit_any;
    logic [4:0]  hit_idx;
    logic [31:0] cand_sel;
    logic        sync_ok;
    logic        at_sync;
    logic [15:0] wc_next;
    logic [3:0]  good_inc;
    logic [3:0]  miss_inc;

    // Candidate search over all 32 offsets; lowest matching offset wins.
    always_comb begin
        window  = {IN_DATA_i, prev_q};
        hit_vec = 32'd0;
        hit_idx = 5'd0;
        for (int k = 0; k < 32; k++) begin
            hit_vec[k] = (window[k +: 32] == SYNC_WORD);
        end
        for (int k = 31; k >= 0; k--) begin
            hit_idx = hit_vec[k] ? 5'(k) : hit_idx;
        end
        hit_any  = |hit_vec;
        cand_sel = window[offset_q +: 32];
        sync_ok  = (cand_sel == SYNC_WORD);
        at_sync  = (word_cnt_q == 16'd0);
        wc_next  = (word_cnt_q == WC_LAST) ? 16'd0 : word_cnt_q + 16'd1;
        good_inc = good_cnt_q + 4'd1;
        miss_inc = miss_cnt_q + 4'd1;
    end

    // Next-state and registered-output logic for the HUNT/VERIFY/LOCKED machine.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        word_cnt_d  = word_cnt_q;
        good_cnt_d  = good_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        offset_d    = offset_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        err_cnt_d   = err_cnt_q;
        if (IN_VALID_i) begin
            prev_d = IN_DATA_i;
            case (state_q)
                ST_HUNT: begin
                    if (hit_any) begin
                        offset_d   = hit_idx;
                        word_cnt_d = 16'd1;
                        good_cnt_d = 4'd1;
                        miss_cnt_d = 4'd0;
                        state_d    = (LOCK_N == 4'd1) ? ST_LOCKED : ST_VERIFY;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_VERIFY: begin
                    word_cnt_d = wc_next;
                    if (at_sync && sync_ok) begin
                        good_cnt_d = good_inc;
                        if (good_inc == LOCK_N) begin
                            state_d    = ST_LOCKED;
                            miss_cnt_d = 4'd0;
                        end else begin
                            state_d = ST_VERIFY;
                        end
                    end else if (at_sync) begin
                        state_d    = ST_HUNT;
                        good_cnt_d = 4'd0;
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end
                ST_LOCKED: begin
                    word_cnt_d  = wc_next;
                    out_data_d  = cand_sel;
                    out_valid_d = 1'b1;
                    out_sof_d   = at_sync;
                    if (at_sync && sync_ok) begin
                        miss_cnt_d = 4'd0;
                    end else if (at_sync) begin
                        miss_cnt_d = miss_inc;
                        err_cnt_d  = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
                        // The word that breaks lock is not forwarded.
                        if (miss_inc == MISS_N) begin
                            state_d     = ST_HUNT;
                            miss_cnt_d  = 4'd0;
                            good_cnt_d  = 4'd0;
                            out_data_d  = out_data_q;
                            out_valid_d = 1'b0;
                            out_sof_d   = 1'b0;
                        end else begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end else begin
            prev_d = prev_q;
        end
        if (ERR_CLR_i) begin
            err_cnt_d = 16'd0;
        end else begin
            err_cnt_d = err_cnt_d;
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge RX_WORDCLK_i) begin
        if (RX_RESET_i) begin
            state_q     <= ST_HUNT;
            prev_q      <= 32'd0;
            word_cnt_q  <= 16'd0;
            good_cnt_q  <= 4'd0;
            miss_cnt_q  <= 4'd0;
            offset_q    <= 5'd0;
            out_data_q  <= 32'd0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            locked_q    <= 1'b0;
            err_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            word_cnt_q  <= word_cnt_d;
            good_cnt_q  <= good_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            offset_q    <= offset_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            locked_q    <= locked_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign OUT_DATA_o     = out_data_q;
    assign OUT_VALID_o    = out_valid_q;
    assign OUT_SOF_o      = out_sof_q;
    assign LOCKED_o       = locked_q;
    assign OFFSET_o       = offset_q;
    assign SYNC_ERR_CNT_o = err_cnt_q;

endmodule

// File: tb/tb_rx_word_aligner.sv
// Directed bench for rx_word_aligner: 16-word frames (sync + ramp 1..15) carried on a
// bit stream rotated by 13 bits, with expected values derived from the frame layout.
module tb_rx_word_aligner;
    localparam logic [31:0] SYNC = 32'h1ACFFC1D;
    localparam logic [31:0] BAD  = 32'h1ACFFC1C;
    localparam int          ROT  = 13;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        err_clr;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_sof;
    logic        locked;
    logic [4:0]  offset;
    logic [15:0] err_cnt;

    int errors;
    int checks;
    logic [31:0] aw [0:255];
    logic [31:0] exp_last;

    rx_word_aligner dut (
        .RX_WORDCLK_i  (clk),
        .RX_RESET_i    (rst),
        .IN_DATA_i     (in_data),
        .IN_VALID_i    (in_valid),
        .ERR_CLR_i     (err_clr),
        .OUT_DATA_o    (out_data),
        .OUT_VALID_o   (out_valid),
        .OUT_SOF_o     (out_sof),
        .LOCKED_o      (locked),
        .OFFSET_o      (offset),
        .SYNC_ERR_CNT_o(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic v);
        in_data  = d;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        send(SYNC, 1'b1);
        send(SYNC, 1'b1);
        rst = 1'b0;
        exp_last = 32'd0;
    endtask

    // Aligned word n: aw[0] is filler, frames start at n=1.
    task automatic fill_stream();
        aw[0] = 32'd0;
        for (int n = 1; n < 256; n++) begin
            aw[n] = (((n - 1) % 16) == 0) ? SYNC : 32'((n - 1) % 16);
        end
    endtask

    function automatic logic [31:0] raw_at(input int n);
        logic [63:0] t;
        t = {aw[n + 1], aw[n]};
        t = t >> (32 - ROT);
        return t[31:0];
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_data"}, out_data, 32'd0);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_sof"}, {31'd0, out_sof}, 32'd0);
        check({tag, "_locked"}, {31'd0, locked}, 32'd0);
        check({tag, "_offset"}, {27'd0, offset}, 32'd0);
        check({tag, "_errcnt"}, {16'd0, err_cnt}, 32'd0);
    endtask

    // Expectations after the edge that consumed aligned word n of a clean stream.
    task automatic expect_word(input int n);
        if (n == 1) check("offset", {27'd0, offset}, 32'd13);
        if (n == 32) check("lock_early", {31'd0, locked}, 32'd0);
        if (n == 33) begin
            check("lock_rise", {31'd0, locked}, 32'd1);
            check("no_valid_at_lock", {31'd0, out_valid}, 32'd0);
        end
        if (n >= 34) begin
            check("valid", {31'd0, out_valid}, 32'd1);
            check("data", out_data, aw[n]);
            check("sof", {31'd0, out_sof}, (((n - 1) % 16) == 0) ? 32'd1 : 32'd0);
            exp_last = aw[n];
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b0;
        in_data  = 32'd0;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        exp_last = 32'd0;

        // Reset state, then rotated stream locks
        do_reset();
        check_zero("reset");
        fill_stream();
        for (int n = 0; n <= 70; n++) begin
            send(raw_at(n), 1'b1);
            expect_word(n);
        end

        // False hit at offset 0 followed by a non-sync word 16 words later
        do_reset();
        send(SYNC, 1'b1);
        for (int c = 1; c <= 17; c++) begin
            send(32'd0, 1'b1);
            if (c == 1) check("false_offset", {27'd0, offset}, 32'd0);
            if (c == 1) check("false_lock1", {31'd0, locked}, 32'd0);
            if (c == 17) check("false_lock17", {31'd0, locked}, 32'd0);
        end
        for (int n = 0; n <= 40; n++) begin
            send(raw_at(n), 1'b1);
            expect_word(n);
        end

        // Miss limit: 3 misses hold lock, the 4th drops it
        do_reset();
        fill_stream();
        aw[49] = BAD;
        aw[65] = BAD;
        aw[81] = BAD;
        aw[97] = BAD;
        for (int n = 0; n <= 99; n++) begin
            send(raw_at(n), 1'b1);
            if (n <= 48) expect_word(n);
            if (n == 49) begin
                check("miss_valid", {31'd0, out_valid}, 32'd1);
                check("miss_sof", {31'd0, out_sof}, 32'd1);
                check("miss_data", out_data, BAD);
                check("miss_err1", {16'd0, err_cnt}, 32'd1);
            end
            if (n == 81) begin
                check("miss3_locked", {31'd0, locked}, 32'd1);
                check("miss3_err", {16'd0, err_cnt}, 32'd3);
            end
            if (n == 96) check("miss3_still_valid", {31'd0, out_valid}, 32'd1);
            if (n == 97) begin
                check("miss4_locked", {31'd0, locked}, 32'd0);
                check("miss4_valid", {31'd0, out_valid}, 32'd0);
                check("miss4_err", {16'd0, err_cnt}, 32'd4);
            end
            if (n == 98) check("miss4_valid_after", {31'd0, out_valid}, 32'd0);
        end

        // Miss recovery, then error clear coinciding with a miss
        do_reset();
        fill_stream();
        aw[49]  = BAD;
        aw[65]  = BAD;
        aw[97]  = BAD;
        aw[113] = BAD;
        aw[129] = BAD;
        for (int n = 0; n <= 130; n++) begin
            err_clr = (n == 129);
            send(raw_at(n), 1'b1);
            err_clr = 1'b0;
            if (n == 81) begin
                check("recov_locked", {31'd0, locked}, 32'd1);
                check("recov_err", {16'd0, err_cnt}, 32'd2);
            end
            if (n == 113) begin
                check("recov_locked2", {31'd0, locked}, 32'd1);
                check("recov_err2", {16'd0, err_cnt}, 32'd4);
            end
            if (n == 129) begin
                check("clr_locked", {31'd0, locked}, 32'd1);
                check("clr_err", {16'd0, err_cnt}, 32'd0);
            end
        end

        // Gapped input: every third cycle idle with junk on the data bus
        do_reset();
        fill_stream();
        begin
            int n;
            n = 0;
            for (int c = 0; n <= 70; c++) begin
                if ((c % 3) == 2) begin
                    send(32'hFFFFFFFF, 1'b0);
                    check("gap_valid", {31'd0, out_valid}, 32'd0);
                    check("gap_sof", {31'd0, out_sof}, 32'd0);
                    check("gap_hold", out_data, exp_last);
                end else begin
                    send(raw_at(n), 1'b1);
                    expect_word(n);
                    n++;
                end
            end
        end

        // Reset while locked mid-frame, then reacquire
        do_reset();
        fill_stream();
        for (int n = 0; n <= 40; n++) begin
            send(raw_at(n), 1'b1);
        end
        check("pre_rst_locked", {31'd0, locked}, 32'd1);
        rst = 1'b1;
        send(raw_at(41), 1'b1);
        rst = 1'b0;
        exp_last = 32'd0;
        check_zero("midrst");
        for (int n = 0; n <= 40; n++) begin
            send(raw_at(n), 1'b1);
            expect_word(n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
